// File: rtl/tp_ram_pipe.sv
// Two-port (1W/1R) SRAM model: byte enables, req/gnt/rvalid read handshake with
// back-pressure, read latency 1 or 2, range errors. TP_RAM_PARITY_EN adds byte parity.
module tp_ram_pipe #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_BYTES    = 4096,
  parameter int READ_LATENCY = 1,
  parameter int RDW_NEW_DATA = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_req_i,
  output logic                    wr_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
`ifdef TP_RAM_PARITY_EN
  input  logic [DATA_WIDTH/8-1:0] dbg_par_flip_i,
`endif
  input  logic                    rd_req_i,
  output logic                    rd_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic                    rd_rvalid_o,
  output logic [DATA_WIDTH-1:0]   rd_rdata_o,
  output logic                    rd_err_o,
  input  logic                    rd_ready_i,
  output logic                    wr_err_o
);
  localparam int          NB    = DATA_WIDTH / 8;
  localparam int          OFFS  = $clog2(NB);
  localparam int unsigned WORDS = NUM_BYTES / NB;
  localparam int          IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int          XW    = ADDR_WIDTH - OFFS;

  logic [XW-1:0] wr_idx, rd_idx;
  logic          wr_inr, rd_inr, wr_en;
  logic          unused_addr_bits;

  assign wr_idx = wr_addr_i[ADDR_WIDTH-1:OFFS];
  assign rd_idx = rd_addr_i[ADDR_WIDTH-1:OFFS];
  assign wr_inr = 32'(wr_idx) < 32'(WORDS);
  assign rd_inr = 32'(rd_idx) < 32'(WORDS);
  assign unused_addr_bits = ^{wr_addr_i, rd_addr_i};

  // Writes are gated by rst_n so a write presented while in reset is dropped.
  assign wr_en    = rst_n && wr_req_i && wr_inr;
  assign wr_gnt_o = rst_n;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
`ifdef TP_RAM_PARITY_EN
  logic [NB-1:0]         par_q [WORDS];
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be_i[b]) begin
          mem_q[wr_idx[IW-1:0]][b*8 +: 8] <= wr_data_i[b*8 +: 8];
`ifdef TP_RAM_PARITY_EN
          par_q[wr_idx[IW-1:0]][b] <= (^wr_data_i[b*8 +: 8]) ^ dbg_par_flip_i[b];
`endif
        end
      end
    end
  end

  // RAM access: merge same-word write bytes when new-data forwarding is selected.
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_hit, rd_err_now;
`ifdef TP_RAM_PARITY_EN
  logic [NB-1:0]         rd_par;
`endif

  always_comb begin
    rd_word    = '0;
    rd_hit     = (RDW_NEW_DATA != 0) && wr_en && (wr_idx == rd_idx);
    rd_err_now = !rd_inr;
`ifdef TP_RAM_PARITY_EN
    rd_par     = '0;
`endif
    if (rd_inr) begin
      rd_word = mem_q[rd_idx[IW-1:0]];
`ifdef TP_RAM_PARITY_EN
      rd_par  = par_q[rd_idx[IW-1:0]];
`endif
    end
    for (int b = 0; b < NB; b++) begin
      if (rd_hit && wr_be_i[b]) begin
        rd_word[b*8 +: 8] = wr_data_i[b*8 +: 8];
`ifdef TP_RAM_PARITY_EN
        rd_par[b] = (^wr_data_i[b*8 +: 8]) ^ dbg_par_flip_i[b];
`endif
      end
    end
`ifdef TP_RAM_PARITY_EN
    if (rd_inr) begin
      for (int b = 0; b < NB; b++) begin
        if ((^rd_word[b*8 +: 8]) != rd_par[b]) rd_err_now = 1'b1;
      end
    end
`endif
  end

  // Read pipeline: every stage advances together whenever the output is not stalled,
  // so S1 moves into an empty or draining S2 without a bubble.
  logic                                   stall, rd_acc;
  logic [READ_LATENCY:1]                  vld_pipe_q, err_pipe_q;
  logic [READ_LATENCY:1][DATA_WIDTH-1:0]  data_pipe_q;

  assign stall    = rd_rvalid_o && !rd_ready_i;
  assign rd_gnt_o = rst_n && !stall;
  assign rd_acc   = rd_req_i && rd_gnt_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      err_pipe_q  <= '0;
      data_pipe_q <= '0;
    end else if (!stall) begin
      vld_pipe_q[1] <= rd_acc;
      if (rd_acc) begin
        data_pipe_q[1] <= rd_word;
        err_pipe_q[1]  <= rd_err_now;
      end
      for (int s = 2; s <= READ_LATENCY; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        if (vld_pipe_q[s-1]) begin
          data_pipe_q[s] <= data_pipe_q[s-1];
          err_pipe_q[s]  <= err_pipe_q[s-1];
        end
      end
    end
  end

  assign rd_rvalid_o = vld_pipe_q[READ_LATENCY];
  assign rd_rdata_o  = data_pipe_q[READ_LATENCY];
  assign rd_err_o    = vld_pipe_q[READ_LATENCY] && err_pipe_q[READ_LATENCY];

  logic wr_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_err_q <= 1'b0;
    else        wr_err_q <= wr_req_i && !wr_inr;
  end
  assign wr_err_o = wr_err_q;

endmodule

// File: tb/tb_tp_ram_pipe.sv
// Directed bench for tp_ram_pipe: one latency-1/old-data instance and one
// latency-2/new-data instance share write and read request inputs.
module tb_tp_ram_pipe;
  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_req, rd_req, rdy1, rdy2;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_be, flip;

  logic          wg1, rg1, rv1, re1, we1;
  logic          wg2, rg2, rv2, re2, we2;
  logic [DW-1:0] rd1, rd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tp_ram_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTES(4096),
                .READ_LATENCY(1), .RDW_NEW_DATA(0)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .wr_req_i(wr_req), .wr_gnt_o(wg1), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
`ifdef TP_RAM_PARITY_EN
    .dbg_par_flip_i(flip),
`endif
    .rd_req_i(rd_req), .rd_gnt_o(rg1), .rd_addr_i(rd_addr), .rd_rvalid_o(rv1),
    .rd_rdata_o(rd1), .rd_err_o(re1), .rd_ready_i(rdy1), .wr_err_o(we1));

  tp_ram_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTES(4096),
                .READ_LATENCY(2), .RDW_NEW_DATA(1)) u_l2 (
    .clk(clk), .rst_n(rst_n),
    .wr_req_i(wr_req), .wr_gnt_o(wg2), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
`ifdef TP_RAM_PARITY_EN
    .dbg_par_flip_i(flip),
`endif
    .rd_req_i(rd_req), .rd_gnt_o(rg2), .rd_addr_i(rd_addr), .rd_rvalid_o(rv2),
    .rd_rdata_o(rd2), .rd_err_o(re2), .rd_ready_i(rdy2), .wr_err_o(we2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_req = 1'b1; rd_addr = a;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; rdy1 = 1'b1; rdy2 = 1'b1;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0; flip = '0;
    tick(); tick();
    chk("rst_wgnt", {wg1, wg2}, 2'b00);
    chk("rst_rgnt", {rg1, rg2}, 2'b00);
    chk("rst_rvalid", {rv1, rv2}, 2'b00);
    chk("rst_rdata", {rd1, rd2}, 64'h0);
    chk("rst_err", {re1, re2, we1, we2}, 4'b0000);
    rst_n = 1'b1; #1;
    chk("gnt_after_rst", {wg1, wg2, rg1, rg2}, 4'b1111);

    wr(13'h000, 32'h0000_0A00, 4'hF);
    wr(13'h004, 32'h0000_0A04, 4'hF);
    wr(13'h008, 32'h0000_0A08, 4'hF);
    wr(13'h020, 32'h0000_0000, 4'hF);
    wr(13'h010, 32'hDEAD_BEEF, 4'hF);

    // Full write then read back on both latencies.
    rd(13'h010);
    chk("l1_rvalid", rv1, 1'b1);
    chk("l1_rdata", rd1, 32'hDEAD_BEEF);
    chk("l1_err", re1, 1'b0);
    chk("l2_not_yet", rv2, 1'b0);
    tick();
    chk("l2_rvalid", rv2, 1'b1);
    chk("l2_rdata", rd2, 32'hDEAD_BEEF);
    chk("l1_drop_hold", {rv1, rd1}, {1'b0, 32'hDEAD_BEEF});
    tick();

    wr(13'h010, 32'h1122_3344, 4'b0101);
    rd(13'h010);
    chk("partial_be", rd1, 32'hDE22_BE44);
    tick();

    // Same-word read during write.
    wr_req = 1'b1; wr_addr = 13'h020; wr_data = 32'hAAAA_AAAA; wr_be = 4'hF;
    rd_req = 1'b1; rd_addr = 13'h020;
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    chk("rdw_old", {rv1, rd1}, {1'b1, 32'h0});
    tick();
    chk("rdw_new", {rv2, rd2}, {1'b1, 32'hAAAA_AAAA});
    rd(13'h020);
    chk("rdw_after", rd1, 32'hAAAA_AAAA);
    tick(); tick();

    // Latency-2 back-to-back reads with a 3-cycle stall on the first response.
    rd_req = 1'b1; rd_addr = 13'h000;
    tick();
    rd_addr = 13'h004;
    tick();
    chk("stall_first", {rv2, rd2}, {1'b1, 32'h0000_0A00});
    rdy2 = 1'b0; rd_addr = 13'h008;
    wr_req = 1'b1; wr_addr = 13'h004; wr_data = 32'h0000_BBBB; wr_be = 4'hF;
    #1;
    chk("stall_gnt0", rg2, 1'b0);
    tick();
    wr_req = 1'b0;
    chk("stall_gnt1", rg2, 1'b0);
    chk("stall_hold1", {rv2, rd2}, {1'b1, 32'h0000_0A00});
    tick(); tick();
    chk("stall_hold3", {rv2, rd2, rg2}, {1'b1, 32'h0000_0A00, 1'b0});
    rdy2 = 1'b1; #1;
    chk("resume_gnt", rg2, 1'b1);
    tick();
    rd_req = 1'b0;
    chk("resp_b", {rv2, rd2}, {1'b1, 32'h0000_0A04});
    tick();
    chk("resp_c", {rv2, rd2}, {1'b1, 32'h0000_0A08});
    tick();
    chk("resp_end", rv2, 1'b0);
    rd(13'h004);
    chk("stall_write_done", rd1, 32'h0000_BBBB);
    tick();

    // Out-of-range read and write.
    rd(13'h1000);
    chk("oor_rd_l1", {rv1, rd1, re1}, {1'b1, 32'h0, 1'b1});
    tick();
    chk("oor_rd_l1_clr", {rv1, re1}, 2'b00);
    chk("oor_rd_l2", {rv2, rd2, re2}, {1'b1, 32'h0, 1'b1});
    wr(13'h1000, 32'hFFFF_FFFF, 4'hF);
    chk("oor_wr_pulse", {we1, we2}, 2'b11);
    tick();
    chk("oor_wr_clr", {we1, we2}, 2'b00);
    rd(13'h000);
    chk("oor_wr_untouched", {rd1, re1}, {32'h0000_0A00, 1'b0});
    tick();

    // be=0 is a no-op.
    wr(13'h010, 32'h0000_0000, 4'h0);
    rd(13'h010);
    chk("be0_noop", rd1, 32'hDE22_BE44);
    tick();

    // Reset one cycle after a latency-2 grant; write in the reset cycle is dropped.
    rd(13'h010);
    rst_n = 1'b0;
    wr_req = 1'b1; wr_addr = 13'h010; wr_data = 32'h5555_5555; wr_be = 4'hF;
    #1;
    chk("midrst_clear", {rv1, rv2, rg2}, 3'b000);
    tick();
    wr_req = 1'b0; rst_n = 1'b1;
    tick();
    chk("midrst_norv1", rv2, 1'b0);
    tick();
    chk("midrst_norv2", rv2, 1'b0);
    rd(13'h010);
    chk("rst_write_dropped", rd1, 32'hDE22_BE44);
    tick();

`ifdef TP_RAM_PARITY_EN
    flip = 4'b0001;
    wr(13'h030, 32'h1234_5678, 4'hF);
    flip = 4'b0000;
    rd(13'h030);
    chk("par_err", {rv1, rd1, re1}, {1'b1, 32'h1234_5678, 1'b1});
    wr(13'h034, 32'h1234_5678, 4'hF);
    rd(13'h034);
    chk("par_ok", {rv1, re1}, 2'b10);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
